// File: rtl/decode_cycle_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_cycle_if : fetch/writeback-to-decode and ID/EX bundle          |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface decode_cycle_if #(
   parameter int XLEN = 32
);
   logic [31:0]     InstrD;
   logic [XLEN-1:0] PCD;
   logic [XLEN-1:0] PCPlus4D;
   logic            FlushE;
   logic            RegWriteW;
   logic [4:0]      RDW;
   logic [XLEN-1:0] ResultW;

   logic            RegWriteE;
   logic            ResultSrcE;
   logic            MemWriteE;
   logic            JumpE;
   logic            BranchE;
   logic            ALUSrcE;
   logic [2:0]      ALUControlE;
   logic [XLEN-1:0] RD1E;
   logic [XLEN-1:0] RD2E;
   logic [XLEN-1:0] ImmExtE;
   logic [4:0]      RS1E;
   logic [4:0]      RS2E;
   logic [4:0]      RDE;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] PCPlus4E;

   modport master (
      output InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RDW, ResultW,
      input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
             ALUControlE, RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE, PCE, PCPlus4E
   );

   modport slave (
      input  InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RDW, ResultW,
      output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
             ALUControlE, RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE, PCE, PCPlus4E
   );
endinterface
`default_nettype wire

// File: rtl/decode_cycle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_cycle : RV32I decode stage, register file and ID/EX register  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module decode_cycle #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic           clk,
   input  logic           rst,
   decode_cycle_if.slave  bus
);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [2:0] IMM_NONE = 3'd0;
   localparam logic [2:0] IMM_I    = 3'd1;
   localparam logic [2:0] IMM_S    = 3'd2;
   localparam logic [2:0] IMM_B    = 3'd3;
   localparam logic [2:0] IMM_J    = 3'd4;

   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;

   assign instr  = bus.InstrD;
   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign rd     = instr[11:7];

   // ---------------- main decoder ----------------
   logic       reg_write;
   logic       result_src;
   logic       mem_write;
   logic       jump;
   logic       branch;
   logic       alu_src;
   logic       alu_from_funct;
   logic [2:0] alu_fixed;
   logic [2:0] imm_sel;

   always_comb begin
      reg_write      = 1'b0;
      result_src     = 1'b0;
      mem_write      = 1'b0;
      jump           = 1'b0;
      branch         = 1'b0;
      alu_src        = 1'b0;
      alu_from_funct = 1'b0;
      alu_fixed      = ALU_ADD;
      imm_sel        = IMM_NONE;
      case (opcode)
         OP_R: begin
            reg_write      = 1'b1;
            alu_from_funct = 1'b1;
         end
         OP_I: begin
            reg_write      = 1'b1;
            alu_src        = 1'b1;
            alu_from_funct = 1'b1;
            imm_sel        = IMM_I;
         end
         OP_LW: begin
            reg_write  = 1'b1;
            alu_src    = 1'b1;
            result_src = 1'b1;
            imm_sel    = IMM_I;
         end
         OP_SW: begin
            mem_write = 1'b1;
            alu_src   = 1'b1;
            imm_sel   = IMM_S;
         end
         OP_BEQ: begin
            branch    = 1'b1;
            alu_fixed = ALU_SUB;
            imm_sel   = IMM_B;
         end
         OP_JAL: begin
            jump      = 1'b1;
            reg_write = 1'b1;
            imm_sel   = IMM_J;
         end
         default: ;
      endcase
   end

   // ---------------- ALU decoder ----------------
   // funct7[5] selects sub only for register-register ops; on I-type that
   // bit belongs to the immediate.
   logic [2:0] alu_funct;
   logic [2:0] alu_ctrl;

   always_comb begin
      alu_funct = ALU_ADD;
      case (funct3)
         3'b000:  alu_funct = (opcode == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_funct = ALU_SLT;
         3'b110:  alu_funct = ALU_OR;
         3'b111:  alu_funct = ALU_AND;
         default: alu_funct = ALU_ADD;
      endcase
      alu_ctrl = alu_from_funct ? alu_funct : alu_fixed;
   end

   // ---------------- immediate generator ----------------
   logic [XLEN-1:0] imm_ext;

   always_comb begin
      imm_ext = '0;
      case (imm_sel)
         IMM_I:   imm_ext = {{(XLEN-12){instr[31]}}, instr[31:20]};
         IMM_S:   imm_ext = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm_ext = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
         IMM_J:   imm_ext = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
         default: imm_ext = '0;
      endcase
   end

   // ---------------- register file ----------------
   logic [XLEN-1:0] regs [NREGS];
   logic            wb_en;

   assign wb_en = bus.RegWriteW && (bus.RDW != 5'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_en) begin
         regs[bus.RDW] <= bus.ResultW;
      end
   end

   // Same-cycle writeback is forwarded so decode never sees a stale value.
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;

   always_comb begin
      rd1 = regs[rs1];
      if (rs1 == 5'd0) begin
         rd1 = '0;
      end else if (wb_en && bus.RDW == rs1) begin
         rd1 = bus.ResultW;
      end
   end

   always_comb begin
      rd2 = regs[rs2];
      if (rs2 == 5'd0) begin
         rd2 = '0;
      end else if (wb_en && bus.RDW == rs2) begin
         rd2 = bus.ResultW;
      end
   end

   // ---------------- ID/EX register ----------------
   logic            ex_reg_write;
   logic            ex_result_src;
   logic            ex_mem_write;
   logic            ex_jump;
   logic            ex_branch;
   logic            ex_alu_src;
   logic [2:0]      ex_alu_ctrl;
   logic [XLEN-1:0] ex_rd1;
   logic [XLEN-1:0] ex_rd2;
   logic [XLEN-1:0] ex_imm;
   logic [4:0]      ex_rs1;
   logic [4:0]      ex_rs2;
   logic [4:0]      ex_rd;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_pc4;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_reg_write  <= 1'b0;
         ex_result_src <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_jump       <= 1'b0;
         ex_branch     <= 1'b0;
         ex_alu_src    <= 1'b0;
         ex_alu_ctrl   <= 3'b000;
         ex_rd1        <= '0;
         ex_rd2        <= '0;
         ex_imm        <= '0;
         ex_rs1        <= 5'd0;
         ex_rs2        <= 5'd0;
         ex_rd         <= 5'd0;
         ex_pc         <= '0;
         ex_pc4        <= '0;
      end else begin
         ex_rd1 <= rd1;
         ex_rd2 <= rd2;
         ex_imm <= imm_ext;
         ex_pc  <= bus.PCD;
         ex_pc4 <= bus.PCPlus4D;
         if (bus.FlushE) begin
            ex_reg_write  <= 1'b0;
            ex_result_src <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_jump       <= 1'b0;
            ex_branch     <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_alu_ctrl   <= 3'b000;
            ex_rs1        <= 5'd0;
            ex_rs2        <= 5'd0;
            ex_rd         <= 5'd0;
         end else begin
            ex_reg_write  <= reg_write;
            ex_result_src <= result_src;
            ex_mem_write  <= mem_write;
            ex_jump       <= jump;
            ex_branch     <= branch;
            ex_alu_src    <= alu_src;
            ex_alu_ctrl   <= alu_ctrl;
            ex_rs1        <= rs1;
            ex_rs2        <= rs2;
            ex_rd         <= rd;
         end
      end
   end

   assign bus.RegWriteE   = ex_reg_write;
   assign bus.ResultSrcE  = ex_result_src;
   assign bus.MemWriteE   = ex_mem_write;
   assign bus.JumpE       = ex_jump;
   assign bus.BranchE     = ex_branch;
   assign bus.ALUSrcE     = ex_alu_src;
   assign bus.ALUControlE = ex_alu_ctrl;
   assign bus.RD1E        = ex_rd1;
   assign bus.RD2E        = ex_rd2;
   assign bus.ImmExtE     = ex_imm;
   assign bus.RS1E        = ex_rs1;
   assign bus.RS2E        = ex_rs2;
   assign bus.RDE         = ex_rd;
   assign bus.PCE         = ex_pc;
   assign bus.PCPlus4E    = ex_pc4;

endmodule
`default_nettype wire
